// File: rtl/gpio_event_blinker.sv
// Turns single-cycle detection strobes into visible blinks on a GPIO/LED pin,
// queueing bursts in a saturating counter and blinking a heartbeat when idle.
module gpio_event_blinker #(
  parameter int ON_CYCLES  = 5_000_000,
  parameter int OFF_CYCLES = 5_000_000,
  parameter int HB_CYCLES  = 134_217_728,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable_i,
  input  logic             event_i,
  input  logic             clear_i,
  output logic             gpio_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             dropped_o
);

  localparam int MAX_PH = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int HW     = $clog2(HB_CYCLES);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [HW-1:0] HB_LAST  = HW'(HB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t          state_reg;
  logic [TW-1:0]   timer_reg;
  logic [HW-1:0]   hb_reg;
  logic            start_evt;
  logic            at_max;

  // An event blink only starts from IDLE with something queued.
  assign start_evt = (state_reg == IDLE) && enable_i && (pending_o != '0);
  assign at_max    = &pending_o;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      timer_reg <= '0;
      hb_reg    <= '0;
      gpio_o    <= 1'b0;
      busy_o    <= 1'b0;
      pending_o <= '0;
      dropped_o <= 1'b0;
    end else begin
      // Simultaneous +1/-1 cancel, so a decrement at max is never a drop.
      if (clear_i) begin
        pending_o <= '0;
        dropped_o <= 1'b0;
      end else if (event_i && !start_evt) begin
        if (at_max)
          dropped_o <= 1'b1;
        else
          pending_o <= pending_o + CNT_W'(1);
      end else if (!event_i && start_evt) begin
        pending_o <= pending_o - CNT_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start_evt || (enable_i && hb_reg == HB_LAST)) begin
            state_reg <= ON;
            gpio_o    <= 1'b1;
            busy_o    <= 1'b1;
            timer_reg <= '0;
            hb_reg    <= '0;
          end else if (enable_i) begin
            hb_reg <= hb_reg + HW'(1);
          end
        end
        ON: begin
          if (timer_reg == ON_LAST) begin
            state_reg <= OFF;
            gpio_o    <= 1'b0;
            timer_reg <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        OFF: begin
          if (timer_reg == OFF_LAST) begin
            state_reg <= IDLE;
            busy_o    <= 1'b0;
            timer_reg <= '0;
            hb_reg    <= '0;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          gpio_o    <= 1'b0;
          busy_o    <= 1'b0;
          timer_reg <= '0;
        end
      endcase
    end
  end

endmodule
